// File: rtl/updn_cnt_pkg.sv
// Shared encodings for the up/down counter generator: count modes and bounce FSM states.
package updn_cnt_pkg;

    typedef enum logic [1:0] {
        WRAP   = 2'b00,
        SAT    = 2'b01,
        BOUNCE = 2'b10,
        HOLD   = 2'b11
    } mode_e;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } state_e;

endpackage

// File: rtl/updn_cnt_next.sv
// Combinational next count, next direction state and terminal-count event for updn_cnt_gen.
// Latency: none (pure logic); backpressure: none, en gates every step.
module updn_cnt_next
    import updn_cnt_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MIN   = 0,
    parameter int MAX   = 15
) (
    input  logic [WIDTH-1:0] cnt_i,
    input  state_e           state_i,
    input  logic             en_i,
    input  logic             up_dn_i,
    input  mode_e            mode_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] cnt_o,
    output state_e           state_o,
    output logic             evt_o
);

    localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic   at_max;
    logic   at_min;
    state_e cmd_dir;

    // Bounds are tested before stepping so the WIDTH-bit add/subtract never leaves [MIN,MAX].
    assign at_max  = (cnt_i >= MAX_V);
    assign at_min  = (cnt_i <= MIN_V);
    assign cmd_dir = up_dn_i ? DOWN : UP;

    always_comb begin
        cnt_o   = cnt_i;
        state_o = state_i;
        evt_o   = 1'b0;
        if (load_i) begin
            if (load_val_i < MIN_V) begin
                cnt_o = MIN_V;
            end else if (load_val_i > MAX_V) begin
                cnt_o = MAX_V;
            end else begin
                cnt_o = load_val_i;
            end
            if (mode_i != BOUNCE) begin
                state_o = cmd_dir;
            end
        end else if (en_i) begin
            if (mode_i != BOUNCE) begin
                state_o = cmd_dir;
            end
            unique case (mode_i)
                WRAP: begin
                    if (cmd_dir == UP) begin
                        cnt_o = at_max ? MIN_V : cnt_i + 1'b1;
                        evt_o = at_max;
                    end else begin
                        cnt_o = at_min ? MAX_V : cnt_i - 1'b1;
                        evt_o = at_min;
                    end
                end
                SAT: begin
                    if (cmd_dir == UP) begin
                        cnt_o = at_max ? MAX_V : cnt_i + 1'b1;
                        evt_o = at_max;
                    end else begin
                        cnt_o = at_min ? MIN_V : cnt_i - 1'b1;
                        evt_o = at_min;
                    end
                end
                BOUNCE: begin
                    if (state_i == UP) begin
                        if (at_max) begin
                            cnt_o   = MAX_V - 1'b1;
                            state_o = DOWN;
                            evt_o   = 1'b1;
                        end else begin
                            cnt_o = cnt_i + 1'b1;
                        end
                    end else begin
                        if (at_min) begin
                            cnt_o   = MIN_V + 1'b1;
                            state_o = UP;
                            evt_o   = 1'b1;
                        end else begin
                            cnt_o = cnt_i - 1'b1;
                        end
                    end
                end
                HOLD: begin
                    cnt_o = cnt_i;
                end
            endcase
        end
    end

endmodule

// File: rtl/updn_cnt_gen.sv
// Up/down counter with WRAP/SAT/BOUNCE/HOLD modes; tc pulse built only with UPDN_CNT_TC_EN.
// Latency: one register stage from inputs to cnt/dir/tc; backpressure: none, en gates stepping.
module updn_cnt_gen
    import updn_cnt_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MIN   = 0,
    parameter int MAX   = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic             dir,
    output logic             tc
);

    generate
        if (MIN >= MAX || MAX > (1 << WIDTH) - 1) begin : g_bad_bounds
            $error("updn_cnt_gen: need MIN < MAX <= 2**WIDTH-1");
        end
    endgenerate

    logic [WIDTH-1:0] cnt_q, cnt_d;
    state_e           state_q, state_d;
    logic             tc_d;

    updn_cnt_next #(
        .WIDTH (WIDTH),
        .MIN   (MIN),
        .MAX   (MAX)
    ) u_next (
        .cnt_i      (cnt_q),
        .state_i    (state_q),
        .en_i       (en),
        .up_dn_i    (up_dn),
        .mode_i     (mode_e'(mode)),
        .load_i     (load),
        .load_val_i (load_val),
        .cnt_o      (cnt_d),
        .state_o    (state_d),
        .evt_o      (tc_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= WIDTH'(MIN);
            state_q <= UP;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    // Outside BOUNCE the state follows up_dn, so it doubles as the registered effective direction.
    assign cnt = cnt_q;
    assign dir = (state_q == DOWN);

`ifdef UPDN_CNT_TC_EN
    logic tc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tc_q <= 1'b0;
        end else begin
            tc_q <= tc_d;
        end
    end

    assign tc = tc_q;
`else
    logic unused_tc_d;

    assign unused_tc_d = tc_d;
    assign tc          = 1'b0;
`endif

endmodule

// File: tb/tb_updn_cnt_gen.sv
// Self-checking bench for updn_cnt_gen (WIDTH=4, MIN=2, MAX=9): directed scenarios plus random traffic.
module tb_updn_cnt_gen;

    localparam int WIDTH = 4;
    localparam int MIN   = 2;
    localparam int MAX   = 9;
`ifdef UPDN_CNT_TC_EN
    localparam bit TC_ON = 1'b1;
`else
    localparam bit TC_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             up_dn;
    logic [1:0]       mode;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] cnt;
    logic             dir;
    logic             tc;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state: count as an integer, direction 0=up/1=down, pending tc.
    int m_cnt;
    int m_dir;
    bit m_tc;

    always #5 clk = ~clk;

    updn_cnt_gen #(
        .WIDTH (WIDTH),
        .MIN   (MIN),
        .MAX   (MAX)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up_dn    (up_dn),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
        .cnt      (cnt),
        .dir      (dir),
        .tc       (tc)
    );

    task automatic model_reset();
        m_cnt = MIN;
        m_dir = 0;
        m_tc  = 1'b0;
    endtask

    // Rules applied with plain integer arithmetic: modular wrap, clamping, reflection at a bound.
    task automatic model_step();
        int span;
        int d;
        int raw;
        bit ev;
        span = MAX - MIN + 1;
        ev   = 1'b0;
        if (load) begin
            m_cnt = (int'(load_val) < MIN) ? MIN : (int'(load_val) > MAX) ? MAX : int'(load_val);
            if (mode != 2'd2) m_dir = int'(up_dn);
        end else if (en) begin
            if (mode != 2'd2) m_dir = int'(up_dn);
            d   = (m_dir == 1) ? -1 : 1;
            raw = m_cnt + d;
            case (mode)
                2'd0: begin
                    ev    = (raw > MAX) || (raw < MIN);
                    m_cnt = ((raw - MIN) % span + span) % span + MIN;
                end
                2'd1: begin
                    ev    = (raw > MAX) || (raw < MIN);
                    m_cnt = (raw > MAX) ? MAX : (raw < MIN) ? MIN : raw;
                end
                2'd2: begin
                    if ((raw > MAX) || (raw < MIN)) begin
                        ev    = 1'b1;
                        m_cnt = m_cnt - d;
                        m_dir = 1 - m_dir;
                    end else begin
                        m_cnt = raw;
                    end
                end
                default: ;
            endcase
        end
        m_tc = ev & TC_ON;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; up_dn = 1'b0; mode = 2'd0; load = 1'b0; load_val = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if ({cnt, dir, tc} !== {4'(MIN), 1'b0, 1'b0}) $display("FAIL reset_state: cnt=%0d dir=%0b tc=%0b expected cnt=%0d dir=0 tc=0", cnt, dir, tc, MIN);
        else n_pass++;
        rst_n = 1'b1;
        step();
        n_total++;
        if ({cnt, dir, tc} !== {4'(MIN), 1'b0, 1'b0}) $display("FAIL reset_idle_hold: cnt=%0d dir=%0b tc=%0b expected cnt=%0d dir=0 tc=0", cnt, dir, tc, MIN);
        else n_pass++;
    endtask

    task automatic test_wrap();
        int exp_cnt[3] = '{9, 2, 3};
        bit exp_tc[3]  = '{1'b0, 1'b1, 1'b0};
        mode = 2'd0; up_dn = 1'b0; load = 1'b1; load_val = 4'd8; en = 1'b0;
        step();
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_total++;
            if (cnt !== 4'(exp_cnt[i]) || tc !== (exp_tc[i] & TC_ON))
                $display("FAIL wrap_up[%0d]: cnt=%0d tc=%0b expected cnt=%0d tc=%0b", i, cnt, tc, exp_cnt[i], exp_tc[i] & TC_ON);
            else n_pass++;
        end
    endtask

    task automatic test_sat();
        int exp_cnt[4] = '{2, 2, 2, 3};
        bit exp_tc[4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
        mode = 2'd1; up_dn = 1'b1; load = 1'b1; load_val = 4'd3; en = 1'b0;
        step();
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) up_dn = 1'b0;
            step();
            n_total++;
            if (cnt !== 4'(exp_cnt[i]) || tc !== (exp_tc[i] & TC_ON))
                $display("FAIL sat_down[%0d]: cnt=%0d tc=%0b expected cnt=%0d tc=%0b", i, cnt, tc, exp_cnt[i], exp_tc[i] & TC_ON);
            else n_pass++;
        end
    endtask

    task automatic test_bounce();
        int exp_cnt[3] = '{9, 8, 7};
        bit exp_dir[3] = '{1'b0, 1'b1, 1'b1};
        bit exp_tc[3]  = '{1'b0, 1'b1, 1'b0};
        mode = 2'd0; up_dn = 1'b0; load = 1'b1; load_val = 4'd8; en = 1'b0;
        step();
        load = 1'b0; en = 1'b1; mode = 2'd2; up_dn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_total++;
            if (cnt !== 4'(exp_cnt[i]) || dir !== exp_dir[i] || tc !== (exp_tc[i] & TC_ON))
                $display("FAIL bounce[%0d]: cnt=%0d dir=%0b tc=%0b expected cnt=%0d dir=%0b tc=%0b",
                         i, cnt, dir, tc, exp_cnt[i], exp_dir[i], exp_tc[i] & TC_ON);
            else n_pass++;
        end
    endtask

    task automatic test_load_clamp();
        mode = 2'd0; up_dn = 1'b0; en = 1'b1; load = 1'b1; load_val = 4'd12;
        step();
        n_total++;
        if (cnt !== 4'd9 || tc !== 1'b0) $display("FAIL load_high_clamp: cnt=%0d tc=%0b expected cnt=9 tc=0", cnt, tc);
        else n_pass++;
        load_val = 4'd0;
        step();
        n_total++;
        if (cnt !== 4'd2 || tc !== 1'b0) $display("FAIL load_low_clamp: cnt=%0d tc=%0b expected cnt=2 tc=0", cnt, tc);
        else n_pass++;
        mode = 2'd3; load = 1'b0;
        step();
        n_total++;
        if (cnt !== 4'd2 || tc !== 1'b0) $display("FAIL hold_mode: cnt=%0d tc=%0b expected cnt=2 tc=0", cnt, tc);
        else n_pass++;
    endtask

    task automatic test_reset_mid_bounce();
        mode = 2'd0; up_dn = 1'b1; load = 1'b1; load_val = 4'd6; en = 1'b0;
        step();
        load = 1'b0; en = 1'b1; mode = 2'd2;
        step();
        n_total++;
        if (cnt !== 4'd5 || dir !== 1'b1) $display("FAIL bounce_pre_reset: cnt=%0d dir=%0b expected cnt=5 dir=1", cnt, dir);
        else n_pass++;
        rst_n = 1'b0;
        model_reset();
        #2;
        n_total++;
        if ({cnt, dir, tc} !== {4'(MIN), 1'b0, 1'b0}) $display("FAIL async_reset: cnt=%0d dir=%0b tc=%0b expected cnt=%0d dir=0 tc=0", cnt, dir, tc, MIN);
        else n_pass++;
        rst_n = 1'b1;
        step();
        n_total++;
        if (cnt !== 4'd3 || dir !== 1'b0 || tc !== 1'b0) $display("FAIL first_step_after_reset: cnt=%0d dir=%0b tc=%0b expected cnt=3 dir=0 tc=0", cnt, dir, tc);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(99) < 2) begin
                rst_n = 1'b0;
                #1;
                rst_n = 1'b1;
                model_reset();
            end
            en       = ($urandom_range(9) < 8);
            up_dn    = 1'($urandom);
            mode     = ($urandom_range(9) < 6) ? 2'd2 : 2'($urandom);
            load     = ($urandom_range(19) == 0);
            load_val = 4'($urandom);
            step();
            n_total++;
            if (cnt !== 4'(m_cnt) || dir !== 1'(m_dir) || tc !== m_tc)
                $display("FAIL random[%0d]: cnt=%0d dir=%0b tc=%0b expected cnt=%0d dir=%0d tc=%0b",
                         i, cnt, dir, tc, m_cnt, m_dir, m_tc);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_sat();
        test_bounce();
        test_load_clamp();
        test_reset_mid_bounce();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
